// File: rtl/vector_ctrl_pkg.sv
// Shared constants and helpers for the vector control token pipeline.
// Channel indices place the three fixed channels directly above the instruction slices.
package vector_ctrl_pkg;

   localparam int MODE_FULL = 0;
   localparam int MODE_LITE = 1;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ch_tk15(input int slices);
      return slices;
   endfunction

   function automatic int ch_ik15(input int slices);
      return slices + 1;
   endfunction

   function automatic int ch_kap(input int slices);
      return slices + 2;
   endfunction

endpackage

// File: rtl/vector_ctrl_tok.sv
// One req/ack to valid/ready token channel: occupancy counter, ack/valid decode and
// an optional saturating drop counter for lite mode.
module vector_ctrl_tok
   import vector_ctrl_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int LITE  = MODE_FULL,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_req,
   output logic             in_ack,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] drop_cnt,
   output logic             empty
);

   localparam int            CW      = cnt_w(DEPTH);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

   logic [CW-1:0] cnt;
   logic          full;
   logic          pop;
   logic          accept;

   assign full      = (cnt == CNT_MAX);
   assign out_valid = (cnt != '0);
   assign empty     = ~out_valid;
   assign pop       = out_valid && out_ready;

   // NOTE: sequential state is written with <= only, so every always_ff reads pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (accept && !pop) begin
         cnt <= cnt + CW'(1);
      end else if (pop && !accept) begin
         cnt <= cnt - CW'(1);
      end
   end

   if (LITE == MODE_LITE) begin : g_lite
      logic drop;

      // A pop frees a slot in the same edge, so a full channel may still take the beat.
      assign in_ack = !reset;
      assign accept = in_req && !reset && (!full || pop);
      assign drop   = in_req && !reset && full && !pop;

      always_ff @(posedge clk) begin
         if (reset) begin
            drop_cnt <= '0;
         end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
         end
      end
   end else begin : g_full
      // Ack depends on the registered count only, never on out_ready.
      assign in_ack   = !reset && !full;
      assign accept   = in_req && in_ack;
      assign drop_cnt = '0;
   end

endmodule

// File: rtl/vector_ctrl_pipe.sv
// Registered per-tile vector control handshake bridge: SLICES instruction channels plus
// the k15 target, k15 initiator and kap initiator channels, each a token buffer.
module vector_ctrl_pipe
   import vector_ctrl_pkg::*;
#(
   parameter int SLICES = 4,
   parameter int DEPTH  = 2,
   parameter int LITE   = MODE_FULL,
   parameter int CNT_W  = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [SLICES-1:0]       t_instr_req,
   output logic [SLICES-1:0]       t_instr_ack,
   input  logic                    t_k15_req,
   output logic                    t_k15_ack,
   output logic [SLICES-1:0]       instr_valid,
   input  logic [SLICES-1:0]       instr_ready,
   output logic                    tk15_valid,
   input  logic                    tk15_ready,
   input  logic                    ik15_valid,
   output logic                    ik15_ready,
   output logic                    i_k15_req,
   input  logic                    i_k15_ack,
   input  logic                    kap_valid,
   output logic                    kap_ready,
   output logic                    i_kap_req,
   input  logic                    i_kap_ack,
   output logic [SLICES*CNT_W-1:0] drop_cnt,
   output logic                    idle
);

   localparam int NCH     = SLICES + 3;
   localparam int CH_TK15 = ch_tk15(SLICES);
   localparam int CH_IK15 = ch_ik15(SLICES);
   localparam int CH_KAP  = ch_kap(SLICES);

   logic [NCH-1:0]   req;
   logic [NCH-1:0]   ack;
   logic [NCH-1:0]   valid;
   logic [NCH-1:0]   ready;
   logic [NCH-1:0]   empty;
   logic [CNT_W-1:0] drop [NCH];

   assign req[SLICES-1:0] = t_instr_req;
   assign req[CH_TK15]    = t_k15_req;
   assign req[CH_IK15]    = ik15_valid;
   assign req[CH_KAP]     = kap_valid;

   assign ready[SLICES-1:0] = instr_ready;
   assign ready[CH_TK15]    = tk15_ready;
   assign ready[CH_IK15]    = i_k15_ack;
   assign ready[CH_KAP]     = i_kap_ack;

   assign t_instr_ack = ack[SLICES-1:0];
   assign t_k15_ack   = ack[CH_TK15];
   assign ik15_ready  = ack[CH_IK15];
   assign kap_ready   = ack[CH_KAP];

   assign instr_valid = valid[SLICES-1:0];
   assign tk15_valid  = valid[CH_TK15];
   assign i_k15_req   = valid[CH_IK15];
   assign i_kap_req   = valid[CH_KAP];

   // Lite behaviour applies to instruction channels only; fabric channels always back-pressure.
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      vector_ctrl_tok #(
         .DEPTH (DEPTH),
         .LITE  ((i < SLICES) ? LITE : MODE_FULL),
         .CNT_W (CNT_W)
      ) u_tok (
         .clk       (clk),
         .reset     (reset),
         .in_req    (req[i]),
         .in_ack    (ack[i]),
         .out_valid (valid[i]),
         .out_ready (ready[i]),
         .drop_cnt  (drop[i]),
         .empty     (empty[i])
      );
   end

   for (genvar s = 0; s < SLICES; s++) begin : g_drop
      assign drop_cnt[s*CNT_W +: CNT_W] = drop[s];
   end

   assign idle = &empty;

endmodule

// File: tb/tb_vector_ctrl_pipe.sv
// Directed bench for vector_ctrl_pipe: one full-mode and one lite-mode instance, an
// occupancy-level model compared every cycle, plus hand-computed expectations.
module tb_vector_ctrl_pipe;
   import vector_ctrl_pkg::*;

   localparam int DEPTH   = 2;
   localparam int LITE_CW = 4;
   localparam int DMAX    = (1 << LITE_CW) - 1;

   logic clk = 1'b0;
   logic reset;
   logic [6:0] req [2];
   logic [6:0] rdy [2];

   logic [3:0] t_instr_ack [2];
   logic [3:0] instr_valid [2];
   logic       t_k15_ack [2];
   logic       tk15_valid [2];
   logic       ik15_ready [2];
   logic       i_k15_req [2];
   logic       kap_ready [2];
   logic       i_kap_req [2];
   logic       idle [2];
   logic [31:0] drop_f;
   logic [15:0] drop_l;

   int n_vec = 0;
   int n_err = 0;
   bit armed = 1'b0;

   int occ [2][7];
   int drp [2][4];

   always #5 clk = ~clk;

   vector_ctrl_pipe #(.SLICES(4), .DEPTH(DEPTH), .LITE(MODE_FULL), .CNT_W(8)) dut_full (
      .clk(clk), .reset(reset),
      .t_instr_req(req[0][3:0]), .t_instr_ack(t_instr_ack[0]),
      .t_k15_req(req[0][4]), .t_k15_ack(t_k15_ack[0]),
      .instr_valid(instr_valid[0]), .instr_ready(rdy[0][3:0]),
      .tk15_valid(tk15_valid[0]), .tk15_ready(rdy[0][4]),
      .ik15_valid(req[0][5]), .ik15_ready(ik15_ready[0]),
      .i_k15_req(i_k15_req[0]), .i_k15_ack(rdy[0][5]),
      .kap_valid(req[0][6]), .kap_ready(kap_ready[0]),
      .i_kap_req(i_kap_req[0]), .i_kap_ack(rdy[0][6]),
      .drop_cnt(drop_f), .idle(idle[0])
   );

   vector_ctrl_pipe #(.SLICES(4), .DEPTH(DEPTH), .LITE(MODE_LITE), .CNT_W(LITE_CW)) dut_lite (
      .clk(clk), .reset(reset),
      .t_instr_req(req[1][3:0]), .t_instr_ack(t_instr_ack[1]),
      .t_k15_req(req[1][4]), .t_k15_ack(t_k15_ack[1]),
      .instr_valid(instr_valid[1]), .instr_ready(rdy[1][3:0]),
      .tk15_valid(tk15_valid[1]), .tk15_ready(rdy[1][4]),
      .ik15_valid(req[1][5]), .ik15_ready(ik15_ready[1]),
      .i_k15_req(i_k15_req[1]), .i_k15_ack(rdy[1][5]),
      .kap_valid(req[1][6]), .kap_ready(kap_ready[1]),
      .i_kap_req(i_kap_req[1]), .i_kap_ack(rdy[1][6]),
      .drop_cnt(drop_l), .idle(idle[1])
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: each channel is an occupancy number updated from the handshake rules.
   function automatic void model_step(input int k, input int c);
      bit lite = (k == 1) && (c < 4);
      bit pop  = (occ[k][c] > 0) && rdy[k][c];
      bit acc  = 1'b0;
      if (req[k][c]) begin
         if (occ[k][c] < DEPTH) acc = 1'b1;
         else if (lite && pop) acc = 1'b1;
         else if (lite && drp[k][c] < DMAX) drp[k][c]++;
      end
      occ[k][c] = occ[k][c] + int'(acc) - int'(pop);
   endfunction

   always @(posedge clk) begin
      armed = 1'b1;
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c < 7; c++) begin
            if (reset) begin
               occ[k][c] = 0;
               if (c < 4) drp[k][c] = 0;
            end else begin
               model_step(k, c);
            end
         end
      end
   end

   function automatic logic [6:0] exp_ack(input int k);
      logic [6:0] e;
      for (int c = 0; c < 7; c++)
         e[c] = !reset && (((k == 1) && (c < 4)) || (occ[k][c] < DEPTH));
      return e;
   endfunction

   function automatic logic [6:0] exp_valid(input int k);
      logic [6:0] e;
      for (int c = 0; c < 7; c++) e[c] = (occ[k][c] > 0);
      return e;
   endfunction

   function automatic logic exp_idle(input int k);
      logic e = 1'b1;
      for (int c = 0; c < 7; c++) if (occ[k][c] != 0) e = 1'b0;
      return e;
   endfunction

   function automatic logic [15:0] exp_drop_l();
      logic [15:0] e;
      for (int s = 0; s < 4; s++) e[s*4 +: 4] = 4'(drp[1][s]);
      return e;
   endfunction

   always @(negedge clk) begin
      if (armed) begin
         for (int k = 0; k < 2; k++) begin
            check($sformatf("ack[%0d]", k),
                  64'({kap_ready[k], ik15_ready[k], t_k15_ack[k], t_instr_ack[k]}), 64'(exp_ack(k)));
            check($sformatf("valid[%0d]", k),
                  64'({i_kap_req[k], i_k15_req[k], tk15_valid[k], instr_valid[k]}), 64'(exp_valid(k)));
            check($sformatf("idle[%0d]", k), 64'(idle[k]), 64'(exp_idle(k)));
         end
         check("drop_full", 64'(drop_f), 64'h0);
         check("drop_lite", 64'(drop_l), 64'(exp_drop_l()));
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   int pops [4];
   int cnt_a;
   int cnt_b;
   logic [4:0] pattern;

   initial begin
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         req[k] = '0;
         rdy[k] = '0;
      end
      repeat (3) next();
      at_neg();
      check("reset_ack", 64'(t_instr_ack[0]), 64'h0);
      check("reset_idle", 64'(idle[0]), 64'h1);
      check("reset_valid", 64'(instr_valid[1]), 64'h0);

      next();
      reset = 1'b0;
      at_neg();
      check("post_reset_ack", 64'(t_instr_ack[1]), 64'hF);

      // Single beat on slice 0.
      next();
      req[0][0] = 1'b1;
      rdy[0][0] = 1'b1;
      next();
      req[0][0] = 1'b0;
      at_neg();
      check("beat_valid", 64'(instr_valid[0]), 64'h1);
      check("beat_idle", 64'(idle[0]), 64'h0);
      next();
      at_neg();
      check("beat_gone", 64'(instr_valid[0]), 64'h0);
      check("beat_idle_back", 64'(idle[0]), 64'h1);

      // Back-pressure on the k15 target.
      next();
      req[0][4] = 1'b1;
      next();
      next();
      at_neg();
      check("bp_ack_low", 64'(t_k15_ack[0]), 64'h0);
      check("bp_valid", 64'(tk15_valid[0]), 64'h1);
      next();
      rdy[0][4] = 1'b1;
      cnt_a = 0;
      for (int i = 0; i < 3; i++) begin
         at_neg();
         if (tk15_valid[0] && rdy[0][4]) cnt_a++;
         if (i < 2) next();
      end
      check("bp_pops", 64'(cnt_a), 64'd3);
      next();
      req[0][4] = 1'b0;
      at_neg();
      check("bp_after_valid", 64'(tk15_valid[0]), 64'h1);
      check("bp_after_ack", 64'(t_k15_ack[0]), 64'h1);
      next();
      next();
      rdy[0][4] = 1'b0;

      // Streaming on all instruction slices.
      next();
      req[0][3:0] = 4'hF;
      rdy[0][3:0] = 4'hF;
      cnt_b = 0;
      for (int s = 0; s < 4; s++) pops[s] = 0;
      for (int i = 0; i < 100; i++) begin
         at_neg();
         for (int s = 0; s < 4; s++) if (instr_valid[0][s]) pops[s]++;
         if (t_instr_ack[0] != 4'hF) cnt_b++;
         next();
      end
      req[0][3:0] = 4'h0;
      for (int s = 0; s < 4; s++) check($sformatf("stream_pops[%0d]", s), 64'(pops[s]), 64'd99);
      check("stream_ack_bubbles", 64'(cnt_b), 64'd0);
      next();
      rdy[0][3:0] = 4'h0;

      // Lite overflow: slice 1 for 20 beats, slice 2 for 5 beats, no ready.
      req[1][1] = 1'b1;
      req[1][2] = 1'b1;
      cnt_a = 0;
      for (int i = 0; i < 20; i++) begin
         at_neg();
         if (!t_instr_ack[1][1]) cnt_a++;
         next();
         if (i == 4) req[1][2] = 1'b0;
      end
      req[1][1] = 1'b0;
      at_neg();
      check("lite_ack_low_cycles", 64'(cnt_a), 64'd0);
      check("lite_drop_s1", 64'(drop_l[7:4]), 64'd15);
      check("lite_drop_s2", 64'(drop_l[11:8]), 64'd3);
      check("lite_valid_s1", 64'(instr_valid[1][1]), 64'h1);
      // Full with a pop: beat accepted, nothing dropped.
      next();
      req[1][1] = 1'b1;
      rdy[1][1] = 1'b1;
      next();
      req[1][1] = 1'b0;
      at_neg();
      check("lite_pop_full_drop", 64'(drop_l[7:4]), 64'd15);
      check("lite_pop_full_valid", 64'(instr_valid[1][1]), 64'h1);
      rdy[1][2] = 1'b1;
      repeat (3) next();
      rdy[1][2:1] = 2'b00;

      // kap initiator path.
      next();
      req[0][6] = 1'b1;
      rdy[0][6] = 1'b1;
      cnt_a = 0;
      for (int i = 0; i < 5; i++) begin
         at_neg();
         pattern[i] = i_kap_req[0];
         if (!kap_ready[0]) cnt_a++;
         next();
         if (i == 2) req[0][6] = 1'b0;
      end
      check("kap_req_pattern", 64'(pattern), 64'b01110);
      check("kap_ready_low", 64'(cnt_a), 64'd0);
      rdy[0][6] = 1'b0;

      // Reset with the k15 initiator full and lite drop counts non-zero.
      req[0][5] = 1'b1;
      req[1][0] = 1'b1;
      next();
      next();
      next();
      at_neg();
      check("ik15_full_req", 64'(i_k15_req[0]), 64'h1);
      check("ik15_full_ready", 64'(ik15_ready[0]), 64'h0);
      check("lite_s0_dropping", 64'(drop_l[3:0] != 4'h0), 64'h1);
      next();
      reset = 1'b1;
      at_neg();
      check("rst_ready_low", 64'(ik15_ready[0]), 64'h0);
      check("rst_lite_ack_low", 64'(t_instr_ack[1]), 64'h0);
      next();
      at_neg();
      check("rst_ik15_req", 64'(i_k15_req[0]), 64'h0);
      check("rst_ik15_ready", 64'(ik15_ready[0]), 64'h0);
      check("rst_idle", 64'(idle[0]), 64'h1);
      check("rst_drop", 64'(drop_l), 64'h0);
      next();
      reset = 1'b0;
      req[0][5] = 1'b0;
      req[1][0] = 1'b0;
      repeat (3) next();
      at_neg();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
